ir_frame_scheduler: RTL and testbench

- Frame-level sequencer for the IR capture path; replaces the hard-coded step counter in the top level.
- Runs the power-on settle delay, then per frame: raise a write request to the StoreFPGA, enable the capture and DDR-writer datapaths, and handshake Wr_Done/ack with the StoreFPGA.
- Reports per-frame status over the UART transmitter and supervises the frame with a timeout.
- Sits between the top-level glue and the capture, DDR-writer and UART-Tx blocks, all on the 66 MHz global clock.

---
 rtl/ir_frame_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_ir_frame_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_frame_scheduler.sv
// Frame-level sequencer for the IR capture path: startup settle, per-frame
// StoreFPGA handshake, capture/DDR-writer enables, UART status and timeout.
module ir_frame_scheduler #(
  parameter logic [31:0] STARTUP_DLY = 32'h179A7B00,
  parameter int unsigned REQ_CYCLES  = 6,
  parameter logic [31:0] TIMEOUT     = 32'h03EF1480,
  parameter logic [15:0] NUM_FRAMES  = 16'd1,
  parameter logic [7:0]  STATUS_OK   = 8'h55,
  parameter logic [7:0]  STATUS_ERR  = 8'hEE
) (
  input  logic        clk_66MHz_Global,
  input  logic        rst_n,
  input  logic        cap_frame_done,
  input  logic        wr_frame_done,
  input  logic        store_ack,
  input  logic        uart_tx_done,
  output logic        capture_en,
  output logic        ddrwriter_en,
  output logic        wr_req,
  output logic        wr_done,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_dr,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] ST_DELAY  = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  localparam int unsigned      REQ_W    = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(REQ_CYCLES - 1);

  logic [2:0]       state_q,      state_d;
  logic [31:0]      dly_cnt_q,    dly_cnt_d;
  logic [REQ_W-1:0] req_cnt_q,    req_cnt_d;
  logic [31:0]      to_cnt_q,     to_cnt_d;
  logic             cap_seen_q,   cap_seen_d;
  logic             wr_seen_q,    wr_seen_d;
  logic             err_q,        err_d;
  logic [7:0]       status_q,     status_d;
  logic [15:0]      frame_cnt_q,  frame_cnt_d;
  logic             ack_meta_q,   ack_s_q;
  logic             capture_en_q, capture_en_d;
  logic             ddr_en_q,     ddr_en_d;
  logic             wr_req_q,     wr_req_d;
  logic             wr_done_q,    wr_done_d;
  logic             tx_en_q,      tx_en_d;
  logic             busy_q,       busy_d;
  logic             timeout_hit;

  assign timeout_hit = (to_cnt_q == TIMEOUT - 32'd1);

  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    req_cnt_d   = req_cnt_q;
    to_cnt_d    = to_cnt_q;
    cap_seen_d  = cap_seen_q;
    wr_seen_d   = wr_seen_q;
    err_d       = err_q;
    status_d    = status_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_DELAY: begin
        if (dly_cnt_q == STARTUP_DLY - 32'd1) begin
          dly_cnt_d = '0;
          req_cnt_d = '0;
          state_d   = ST_REQ;
        end else begin
          dly_cnt_d = dly_cnt_q + 32'd1;
        end
      end
      ST_REQ: begin
        if (req_cnt_q == REQ_LAST) begin
          req_cnt_d  = '0;
          cap_seen_d = 1'b0;
          wr_seen_d  = 1'b0;
          to_cnt_d   = '0;
          state_d    = ST_RUN;
        end else begin
          req_cnt_d = req_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        to_cnt_d = to_cnt_q + 32'd1;
        // Timeout wins over any done sampled on the same edge.
        if (timeout_hit) begin
          err_d    = 1'b1;
          status_d = STATUS_ERR;
          state_d  = ST_REPORT;
        end else begin
          cap_seen_d = cap_seen_q | cap_frame_done;
          wr_seen_d  = wr_seen_q | wr_frame_done;
          if (cap_seen_d && wr_seen_d) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (timeout_hit) begin
          err_d    = 1'b1;
          status_d = STATUS_ERR;
          state_d  = ST_REPORT;
        end else if (ack_s_q) begin
          status_d = STATUS_OK;
          state_d  = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (uart_tx_done) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (err_q) begin
          state_d = ST_HALT;
        end else if ((NUM_FRAMES != 16'd0) && (frame_cnt_q == NUM_FRAMES)) begin
          state_d = ST_HALT;
        end else if (!ack_s_q) begin
          req_cnt_d = '0;
          state_d   = ST_REQ;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_DELAY;
      end
    endcase
  end

  // Outputs are registered from the next state so the StoreFPGA sees glitch-free
  // levels while keeping the same cycle timing as a state decode.
  always_comb begin
    capture_en_d = (state_d == ST_RUN) && !cap_seen_d;
    ddr_en_d     = (state_d == ST_RUN) && !wr_seen_d;
    wr_req_d     = (state_d == ST_REQ);
    wr_done_d    = (state_d == ST_DONE);
    tx_en_d      = (state_d == ST_REPORT);
    busy_d       = (state_d != ST_HALT);
  end

  always_ff @(posedge clk_66MHz_Global or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_DELAY;
      dly_cnt_q    <= '0;
      req_cnt_q    <= '0;
      to_cnt_q     <= '0;
      cap_seen_q   <= 1'b0;
      wr_seen_q    <= 1'b0;
      err_q        <= 1'b0;
      status_q     <= '0;
      frame_cnt_q  <= '0;
      ack_meta_q   <= 1'b0;
      ack_s_q      <= 1'b0;
      capture_en_q <= 1'b0;
      ddr_en_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      wr_done_q    <= 1'b0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      req_cnt_q    <= req_cnt_d;
      to_cnt_q     <= to_cnt_d;
      cap_seen_q   <= cap_seen_d;
      wr_seen_q    <= wr_seen_d;
      err_q        <= err_d;
      status_q     <= status_d;
      frame_cnt_q  <= frame_cnt_d;
      ack_meta_q   <= store_ack;
      ack_s_q      <= ack_meta_q;
      capture_en_q <= capture_en_d;
      ddr_en_q     <= ddr_en_d;
      wr_req_q     <= wr_req_d;
      wr_done_q    <= wr_done_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
    end
  end

  assign capture_en   = capture_en_q;
  assign ddrwriter_en = ddr_en_q;
  assign wr_req       = wr_req_q;
  assign wr_done      = wr_done_q;
  assign uart_tx_en   = tx_en_q;
  assign uart_tx_dr   = status_q;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ir_frame_scheduler.sv
// Directed bench: a single-frame instance (_s) and a continuous instance (_c)
// share one stimulus stream; expected values are hand-derived cycle counts.
module tb_ir_frame_scheduler;

  logic clk_66MHz_Global = 1'b0;
  logic rst_n;
  logic cap_frame_done, wr_frame_done, store_ack, uart_tx_done;

  logic        capture_en_s, ddrwriter_en_s, wr_req_s, wr_done_s, uart_tx_en_s, busy_s, err_s;
  logic [7:0]  uart_tx_dr_s;
  logic [15:0] frame_cnt_s;
  logic        capture_en_c, ddrwriter_en_c, wr_req_c, wr_done_c, uart_tx_en_c, busy_c, err_c;
  logic [7:0]  uart_tx_dr_c;
  logic [15:0] frame_cnt_c;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_66MHz_Global = ~clk_66MHz_Global;

  ir_frame_scheduler #(
    .STARTUP_DLY(32'd100), .REQ_CYCLES(6), .TIMEOUT(32'd1000), .NUM_FRAMES(16'd1)
  ) dut_s (
    .clk_66MHz_Global(clk_66MHz_Global), .rst_n(rst_n),
    .cap_frame_done(cap_frame_done), .wr_frame_done(wr_frame_done),
    .store_ack(store_ack), .uart_tx_done(uart_tx_done),
    .capture_en(capture_en_s), .ddrwriter_en(ddrwriter_en_s), .wr_req(wr_req_s),
    .wr_done(wr_done_s), .uart_tx_en(uart_tx_en_s), .uart_tx_dr(uart_tx_dr_s),
    .frame_cnt(frame_cnt_s), .busy(busy_s), .err(err_s)
  );

  ir_frame_scheduler #(
    .STARTUP_DLY(32'd100), .REQ_CYCLES(6), .TIMEOUT(32'd1000), .NUM_FRAMES(16'd0)
  ) dut_c (
    .clk_66MHz_Global(clk_66MHz_Global), .rst_n(rst_n),
    .cap_frame_done(cap_frame_done), .wr_frame_done(wr_frame_done),
    .store_ack(store_ack), .uart_tx_done(uart_tx_done),
    .capture_en(capture_en_c), .ddrwriter_en(ddrwriter_en_c), .wr_req(wr_req_c),
    .wr_done(wr_done_c), .uart_tx_en(uart_tx_en_c), .uart_tx_dr(uart_tx_dr_c),
    .frame_cnt(frame_cnt_c), .busy(busy_c), .err(err_c)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_66MHz_Global);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!wr_req_c && n < 300);
  endtask

  task automatic pulse_tx_done();
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int w;
    rst_n = 1'b0;
    cap_frame_done = 1'b0;
    wr_frame_done  = 1'b0;
    store_ack      = 1'b0;
    uart_tx_done   = 1'b0;
    repeat (3) tick();

    chk("rst_capture_en", capture_en_s, 0);
    chk("rst_ddr_en",     ddrwriter_en_s, 0);
    chk("rst_wr_req",     wr_req_s, 0);
    chk("rst_wr_done",    wr_done_s, 0);
    chk("rst_tx_en",      uart_tx_en_s, 0);
    chk("rst_tx_dr",      uart_tx_dr_s, 0);
    chk("rst_frame_cnt",  frame_cnt_s, 0);
    chk("rst_busy",       busy_s, 1);
    chk("rst_err",        err_s, 0);

    // Startup delay and request width.
    rst_n = 1'b1;
    wait_req(n);
    chk("startup_dly", n, 100);
    chk("wr_req_s_rise", wr_req_s, 1);
    w = 1;
    while (w < 50) begin
      tick();
      if (!wr_req_c) break;
      w++;
    end
    chk("req_width", w, 6);
    chk("run_cap_en", capture_en_s, 1);
    chk("run_ddr_en", ddrwriter_en_s, 1);

    // Frame 1: cap at +50, wr at +80, ack at +120.
    repeat (49) tick();
    cap_frame_done = 1'b1; tick(); cap_frame_done = 1'b0;
    chk("f1_cap_drop", capture_en_s, 0);
    chk("f1_ddr_hold", ddrwriter_en_s, 1);
    repeat (29) tick();
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    chk("f1_ddr_drop", ddrwriter_en_s, 0);
    chk("f1_wr_done",  wr_done_s, 1);
    repeat (39) tick();
    store_ack = 1'b1;
    tick(); tick();
    chk("f1_wr_done_sync", wr_done_s, 1);
    tick();
    chk("f1_wr_done_clr", wr_done_s, 0);
    chk("f1_tx_en",       uart_tx_en_s, 1);
    chk("f1_tx_dr_s",     uart_tx_dr_s, 8'h55);
    chk("f1_tx_dr_c",     uart_tx_dr_c, 8'h55);
    repeat (3) tick();
    chk("f1_tx_en_hold",  uart_tx_en_s, 1);
    pulse_tx_done();
    chk("f1_tx_en_clr",   uart_tx_en_s, 0);
    chk("f1_cnt_s",       frame_cnt_s, 1);
    chk("f1_cnt_c",       frame_cnt_c, 1);
    tick();
    chk("f1_halt_busy_s", busy_s, 0);
    chk("f1_next_busy_c", busy_c, 1);

    // Continuous mode: ack held high blocks the next request.
    repeat (10) tick();
    chk("ack_hold_no_req", wr_req_c, 0);
    store_ack = 1'b0;
    tick(); tick();
    chk("ack_fall_wait", wr_req_c, 0);
    tick();
    chk("ack_fall_req", wr_req_c, 1);
    chk("halt_no_req_s", wr_req_s, 0);
    chk("halt_busy_s",   busy_s, 0);

    // Frame 2: stray tx_done in RUN, then simultaneous dones.
    repeat (6) tick();
    chk("f2_cap_en", capture_en_c, 1);
    chk("f2_req_lo", wr_req_c, 0);
    pulse_tx_done();
    chk("f2_stray_txdone_cnt", frame_cnt_c, 1);
    chk("halt_cap_en_s", capture_en_s, 0);
    repeat (8) tick();
    cap_frame_done = 1'b1; wr_frame_done = 1'b1;
    tick();
    cap_frame_done = 1'b0; wr_frame_done = 1'b0;
    chk("f2_cap_drop", capture_en_c, 0);
    chk("f2_ddr_drop", ddrwriter_en_c, 0);
    chk("f2_done",     wr_done_c, 1);
    store_ack = 1'b1;
    repeat (3) tick();
    chk("f2_tx_en", uart_tx_en_c, 1);
    chk("f2_tx_dr", uart_tx_dr_c, 8'h55);
    store_ack = 1'b0;
    repeat (3) tick();
    pulse_tx_done();
    chk("f2_cnt", frame_cnt_c, 2);
    tick();
    chk("f2_next_req", wr_req_c, 1);

    // Frame 3: wr before cap.
    repeat (6) tick();
    repeat (29) tick();
    wr_frame_done = 1'b1; tick(); wr_frame_done = 1'b0;
    chk("f3_ddr_drop", ddrwriter_en_c, 0);
    chk("f3_cap_hold", capture_en_c, 1);
    repeat (39) tick();
    chk("f3_cap_hold2", capture_en_c, 1);
    cap_frame_done = 1'b1; tick(); cap_frame_done = 1'b0;
    chk("f3_cap_drop", capture_en_c, 0);
    chk("f3_done",     wr_done_c, 1);
    store_ack = 1'b1;
    repeat (3) tick();
    store_ack = 1'b0;
    repeat (3) tick();
    pulse_tx_done();
    chk("f3_cnt",  frame_cnt_c, 3);
    chk("f3_busy", busy_c, 1);
    tick();
    chk("f4_req",  wr_req_c, 1);

    // Asynchronous reset mid-RUN.
    repeat (6) tick();
    repeat (5) tick();
    chk("pre_rst_cap_en", capture_en_c, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cap_en", capture_en_c, 0);
    chk("arst_ddr_en", ddrwriter_en_c, 0);
    chk("arst_cnt_c",  frame_cnt_c, 0);
    chk("arst_busy_c", busy_c, 1);
    chk("arst_busy_s", busy_s, 1);
    chk("arst_tx_dr",  uart_tx_dr_c, 0);
    tick(); tick();
    rst_n = 1'b1;
    wait_req(n);
    chk("restart_dly", n, 100);

    // Timeout with dones arriving on the timeout cycle.
    repeat (6) tick();
    repeat (999) tick();
    chk("to_pre_cap_en", capture_en_s, 1);
    chk("to_pre_err",    err_s, 0);
    cap_frame_done = 1'b1; wr_frame_done = 1'b1;
    tick();
    cap_frame_done = 1'b0; wr_frame_done = 1'b0;
    chk("to_err_s",   err_s, 1);
    chk("to_err_c",   err_c, 1);
    chk("to_tx_dr",   uart_tx_dr_s, 8'hEE);
    chk("to_cap_en",  capture_en_s, 0);
    chk("to_ddr_en",  ddrwriter_en_s, 0);
    chk("to_wr_done", wr_done_s, 0);
    chk("to_tx_en",   uart_tx_en_s, 1);
    repeat (2) tick();
    pulse_tx_done();
    chk("to_cnt_s", frame_cnt_s, 1);
    tick();
    chk("to_halt_s",    busy_s, 0);
    chk("to_halt_c",    busy_c, 0);
    chk("to_err_stick", err_c, 1);
    chk("to_dr_hold",   uart_tx_dr_c, 8'hEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
